// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI command decoder and BLE packet control register bank.
// Turns received SPI bytes into register reads and writes, returns TX bytes,
// and forwards payload bytes to the external payload buffer.
module spi_reg_bank #(
  parameter int unsigned       SPI_W    = 8,
  parameter int unsigned       ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] PAY_ADDR = ADDR_W'('h10)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_n_i,
  input  logic              rx_valid_i,
  input  logic [SPI_W-1:0]  rx_data_i,
  output logic              tx_load_en_o,
  output logic [SPI_W-1:0]  tx_data_o,
  input  logic              pkt_busy_i,
  output logic              pkt_start_o,
  output logic              tx_enable_o,
  output logic [5:0]        channel_o,
  output logic [31:0]       access_addr_o,
  output logic [7:0]        pay_len_o,
  output logic              pay_wr_en_o,
  output logic [SPI_W-1:0]  pay_wr_data_o
);

  localparam logic [1:0]       ST_IDLE = 2'd0;
  localparam logic [1:0]       ST_CMD  = 2'd1;
  localparam logic [1:0]       ST_DATA = 2'd2;

  localparam logic [SPI_W-1:0] ACK_BYTE     = SPI_W'('hA5);
  localparam logic [31:0]      AA_RESET     = 32'h8E89_BED6;
  localparam logic [5:0]       MAX_CHANNEL  = 6'd39;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              tx_load_q, tx_load_d;
  logic [SPI_W-1:0]  tx_data_q, tx_data_d;
  logic              pkt_start_q, pkt_start_d;
  logic              tx_en_q, tx_en_d;
  logic [5:0]        channel_q, channel_d;
  logic [31:0]       access_addr_q, access_addr_d;
  logic [7:0]        pay_len_q, pay_len_d;
  logic              err_q, err_d;
  logic              pay_wr_en_q, pay_wr_en_d;
  logic [SPI_W-1:0]  pay_wr_data_q, pay_wr_data_d;

  logic [ADDR_W-1:0] rd_addr_c;
  logic [SPI_W-1:0]  rd_data_c;

  // Payload port is a FIFO-style window, so the address does not advance there.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == PAY_ADDR) ? a : a + ADDR_W'(1);
  endfunction

  // Read mux: command byte addresses directly, later bytes use the running address.
  always_comb begin
    rd_addr_c = (state_q == ST_CMD) ? rx_data_i[ADDR_W-1:0] : addr_q;
    rd_data_c = '0;
    case (rd_addr_c)
      ADDR_W'(0): rd_data_c = SPI_W'({tx_en_q, 1'b0});
      ADDR_W'(1): rd_data_c = SPI_W'(channel_q);
      ADDR_W'(2): rd_data_c = SPI_W'(access_addr_q[7:0]);
      ADDR_W'(3): rd_data_c = SPI_W'(access_addr_q[15:8]);
      ADDR_W'(4): rd_data_c = SPI_W'(access_addr_q[23:16]);
      ADDR_W'(5): rd_data_c = SPI_W'(access_addr_q[31:24]);
      ADDR_W'(6): rd_data_c = SPI_W'(pay_len_q);
      ADDR_W'(7): rd_data_c = SPI_W'({err_q, pkt_busy_i});
      default:    rd_data_c = '0;
    endcase
  end

  // Frame FSM, command decode and register write next-state logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_d          = wr_q;
    tx_load_d     = 1'b0;
    tx_data_d     = tx_data_q;
    pkt_start_d   = 1'b0;
    tx_en_d       = tx_en_q;
    channel_d     = channel_q;
    access_addr_d = access_addr_q;
    pay_len_d     = pay_len_q;
    err_d         = err_q;
    pay_wr_en_d   = 1'b0;
    pay_wr_data_d = pay_wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (!cs_n_i) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (cs_n_i) begin
          state_d = ST_IDLE;
        end else if (rx_valid_i) begin
          state_d   = ST_DATA;
          wr_d      = rx_data_i[SPI_W-1];
          tx_load_d = 1'b1;
          if (rx_data_i[SPI_W-1]) begin
            addr_d    = rx_data_i[ADDR_W-1:0];
            tx_data_d = ACK_BYTE;
          end else begin
            addr_d    = next_addr(rx_data_i[ADDR_W-1:0]);
            tx_data_d = rd_data_c;
          end
        end
      end
      ST_DATA: begin
        if (cs_n_i) begin
          state_d = ST_IDLE;
        end else if (rx_valid_i) begin
          tx_load_d = 1'b1;
          addr_d    = next_addr(addr_q);
          if (!wr_q) begin
            tx_data_d = rd_data_c;
          end else begin
            tx_data_d = '0;
            case (addr_q)
              ADDR_W'(0): begin
                tx_en_d = rx_data_i[1];
                if (rx_data_i[0]) begin
                  if (pkt_busy_i) err_d = 1'b1;
                  else            pkt_start_d = 1'b1;
                end
              end
              ADDR_W'(1): begin
                channel_d = rx_data_i[5:0];
                if (rx_data_i[5:0] > MAX_CHANNEL) err_d = 1'b1;
              end
              ADDR_W'(2): access_addr_d[7:0]   = rx_data_i[7:0];
              ADDR_W'(3): access_addr_d[15:8]  = rx_data_i[7:0];
              ADDR_W'(4): access_addr_d[23:16] = rx_data_i[7:0];
              ADDR_W'(5): access_addr_d[31:24] = rx_data_i[7:0];
              ADDR_W'(6): pay_len_d            = rx_data_i[7:0];
              ADDR_W'(7): begin
                if (rx_data_i[1]) err_d = 1'b0;
              end
              PAY_ADDR: begin
                pay_wr_en_d   = 1'b1;
                pay_wr_data_d = rx_data_i;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      tx_load_q     <= 1'b0;
      tx_data_q     <= '0;
      pkt_start_q   <= 1'b0;
      tx_en_q       <= 1'b0;
      channel_q     <= '0;
      access_addr_q <= AA_RESET;
      pay_len_q     <= '0;
      err_q         <= 1'b0;
      pay_wr_en_q   <= 1'b0;
      pay_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      tx_load_q     <= tx_load_d;
      tx_data_q     <= tx_data_d;
      pkt_start_q   <= pkt_start_d;
      tx_en_q       <= tx_en_d;
      channel_q     <= channel_d;
      access_addr_q <= access_addr_d;
      pay_len_q     <= pay_len_d;
      err_q         <= err_d;
      pay_wr_en_q   <= pay_wr_en_d;
      pay_wr_data_q <= pay_wr_data_d;
    end
  end

  assign tx_load_en_o  = tx_load_q;
  assign tx_data_o     = tx_data_q;
  assign pkt_start_o   = pkt_start_q;
  assign tx_enable_o   = tx_en_q;
  assign channel_o     = channel_q;
  assign access_addr_o = access_addr_q;
  assign pay_len_o     = pay_len_q;
  assign pay_wr_en_o   = pay_wr_en_q;
  assign pay_wr_data_o = pay_wr_data_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios plus randomized
// frames checked against a register-map level reference model.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        pkt_busy;
  logic        tx_load_en;
  logic [7:0]  tx_data;
  logic        pkt_start;
  logic        tx_enable;
  logic [5:0]  channel;
  logic [31:0] access_addr;
  logic [7:0]  pay_len;
  logic        pay_wr_en;
  logic [7:0]  pay_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus frame and per-byte observations (sampled one cycle after each byte).
  logic [7:0] frame_q[$];
  logic       obs_load[8];
  logic [7:0] obs_tx[8];
  logic       obs_pw[8];
  logic [7:0] obs_pwd[8];
  logic       obs_ps[8];

  // Reference model state.
  logic        m_tx_en;
  logic [5:0]  m_ch;
  logic [31:0] m_aa;
  logic [7:0]  m_len;
  logic        m_err;
  logic [7:0]  exp_tx[8];
  logic        exp_pw[8];
  logic        exp_ps[8];

  spi_reg_bank dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cs_n_i        (cs_n),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .tx_load_en_o  (tx_load_en),
    .tx_data_o     (tx_data),
    .pkt_busy_i    (pkt_busy),
    .pkt_start_o   (pkt_start),
    .tx_enable_o   (tx_enable),
    .channel_o     (channel),
    .access_addr_o (access_addr),
    .pay_len_o     (pay_len),
    .pay_wr_en_o   (pay_wr_en),
    .pay_wr_data_o (pay_wr_data)
  );

  always #5 clk = ~clk;

  // Drive one complete frame from frame_q and record outputs after each byte.
  task automatic send_frame(input bit gaps);
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = frame_q[i];
      @(negedge clk);
      obs_load[i] = tx_load_en;
      obs_tx[i]   = tx_data;
      obs_pw[i]   = pay_wr_en;
      obs_pwd[i]  = pay_wr_data;
      obs_ps[i]   = pkt_start;
      rx_valid    = 1'b0;
    end
    cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] m_read(input int a);
    case (a)
      0: return {6'b0, m_tx_en, 1'b0};
      1: return {2'b0, m_ch};
      2, 3, 4, 5: return m_aa[8*(a-2) +: 8];
      6: return m_len;
      7: return {6'b0, m_err, pkt_busy};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input int a, input logic [7:0] b, output logic pw, output logic ps);
    pw = 1'b0;
    ps = 1'b0;
    case (a)
      0: begin
        m_tx_en = b[1];
        if (b[0]) begin
          if (pkt_busy) m_err = 1'b1;
          else          ps = 1'b1;
        end
      end
      1: begin
        m_ch = b[5:0];
        if (b[5:0] > 39) m_err = 1'b1;
      end
      2, 3, 4, 5: m_aa[8*(a-2) +: 8] = b;
      6: m_len = b;
      7: if (b[1]) m_err = 1'b0;
      16: pw = 1'b1;
      default: ;
    endcase
  endtask

  // Expected per-byte results for the frame in frame_q; updates model registers.
  task automatic model_frame();
    int   a;
    logic wr;
    logic pw, ps;
    wr = frame_q[0][7];
    a  = int'(frame_q[0][6:0]);
    exp_tx[0] = wr ? 8'hA5 : m_read(a);
    exp_pw[0] = 1'b0;
    exp_ps[0] = 1'b0;
    if (!wr) a = (a == 16) ? a : (a + 1) % 128;
    for (int i = 1; i < frame_q.size(); i++) begin
      pw = 1'b0;
      ps = 1'b0;
      if (wr) begin
        exp_tx[i] = 8'h00;
        m_write(a, frame_q[i], pw, ps);
      end else begin
        exp_tx[i] = m_read(a);
      end
      exp_pw[i] = pw;
      exp_ps[i] = ps;
      a = (a == 16) ? a : (a + 1) % 128;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pkt_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_load_en !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx: load=%0b data=%02h want 0/00", tx_load_en, tx_data); end
    n_cmp++; if (pkt_start !== 1'b0 || tx_enable !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: start=%0b txen=%0b want 0/0", pkt_start, tx_enable); end
    n_cmp++; if (channel !== 6'h00 || pay_len !== 8'h00) begin n_bad++; $display("FAIL reset_regs: ch=%02h len=%02h want 00/00", channel, pay_len); end
    n_cmp++; if (access_addr !== 32'h8E89BED6) begin n_bad++; $display("FAIL reset_aa: got %08h want 8E89BED6", access_addr); end
    n_cmp++; if (pay_wr_en !== 1'b0 || pay_wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_pay: en=%0b data=%02h want 0/00", pay_wr_en, pay_wr_data); end
  endtask

  task automatic test_channel();
    frame_q = '{8'h81, 8'h25};
    send_frame(1'b0);
    n_cmp++; if (obs_load[0] !== 1'b1 || obs_tx[0] !== 8'hA5) begin n_bad++; $display("FAIL chan_ack: load=%0b data=%02h want 1/A5", obs_load[0], obs_tx[0]); end
    n_cmp++; if (channel !== 6'h25) begin n_bad++; $display("FAIL chan_value: got %02h want 25", channel); end
    n_cmp++; if (obs_pw[0] !== 1'b0 || obs_pw[1] !== 1'b0) begin n_bad++; $display("FAIL chan_no_pay: got %0b%0b want 00", obs_pw[0], obs_pw[1]); end
    frame_q = '{8'h07, 8'h00};
    send_frame(1'b0);
    n_cmp++; if (obs_tx[0] !== 8'h00) begin n_bad++; $display("FAIL chan_err_clear: status=%02h want 00", obs_tx[0]); end
  endtask

  task automatic test_access_addr();
    logic [7:0] want[4];
    want = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    frame_q = '{8'h82, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(1'b1);
    n_cmp++; if (access_addr !== 32'hEFBEADDE) begin n_bad++; $display("FAIL aa_write: got %08h want EFBEADDE", access_addr); end
    frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_load[i] !== 1'b1 || obs_tx[i] !== want[i]) begin n_bad++; $display("FAIL aa_read[%0d]: load=%0b data=%02h want 1/%02h", i, obs_load[i], obs_tx[i], want[i]); end
    end
  endtask

  task automatic test_payload();
    logic [7:0] want[3];
    want = '{8'h11, 8'h22, 8'h33};
    frame_q = '{8'h90, 8'h11, 8'h22, 8'h33};
    send_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (obs_pw[i+1] !== 1'b1 || obs_pwd[i+1] !== want[i]) begin n_bad++; $display("FAIL pay_byte[%0d]: en=%0b data=%02h want 1/%02h", i, obs_pw[i+1], obs_pwd[i+1], want[i]); end
    end
    n_cmp++; if (pay_len !== 8'h00) begin n_bad++; $display("FAIL pay_len_kept: got %02h want 00", pay_len); end
  endtask

  task automatic test_start();
    pkt_busy = 1'b0;
    frame_q = '{8'h80, 8'h01};
    send_frame(1'b0);
    n_cmp++; if (obs_ps[1] !== 1'b1 || obs_ps[0] !== 1'b0) begin n_bad++; $display("FAIL start_pulse: got %0b%0b want 01", obs_ps[0], obs_ps[1]); end
    n_cmp++; if (tx_enable !== 1'b0) begin n_bad++; $display("FAIL start_txen: got %0b want 0", tx_enable); end
    pkt_busy = 1'b1;
    send_frame(1'b0);
    n_cmp++; if (obs_ps[1] !== 1'b0) begin n_bad++; $display("FAIL start_busy: pulse=%0b want 0", obs_ps[1]); end
    frame_q = '{8'h07};
    send_frame(1'b0);
    n_cmp++; if (obs_tx[0] !== 8'h03) begin n_bad++; $display("FAIL status_busy_err: got %02h want 03", obs_tx[0]); end
    pkt_busy = 1'b0;
    frame_q = '{8'h87, 8'h02};
    send_frame(1'b0);
    frame_q = '{8'h07};
    send_frame(1'b0);
    n_cmp++; if (obs_tx[0] !== 8'h00) begin n_bad++; $display("FAIL status_clear: got %02h want 00", obs_tx[0]); end
  endtask

  task automatic test_wrap();
    pkt_busy = 1'b0;
    frame_q = '{8'hFF, 8'hAA, 8'hBB};
    send_frame(1'b0);
    n_cmp++; if (tx_enable !== 1'b1) begin n_bad++; $display("FAIL wrap_txen: got %0b want 1", tx_enable); end
    n_cmp++; if (obs_ps[2] !== 1'b1 || obs_ps[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_start: got %0b%0b want 01", obs_ps[1], obs_ps[2]); end
  endtask

  task automatic test_cs_abort();
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h81;
    @(negedge clk); rx_valid = 1'b0; cs_n = 1'b1;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h3F;
    @(negedge clk); rx_valid = 1'b0;
    n_cmp++; if (tx_load_en !== 1'b0) begin n_bad++; $display("FAIL cs_high_load: got %0b want 0", tx_load_en); end
    n_cmp++; if (channel !== 6'h25) begin n_bad++; $display("FAIL cs_high_chan: got %02h want 25", channel); end
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h81;
    @(negedge clk); rx_data = 8'h30; cs_n = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    n_cmp++; if (tx_load_en !== 1'b0 || channel !== 6'h25) begin n_bad++; $display("FAIL cs_rise_byte: load=%0b ch=%02h want 0/25", tx_load_en, channel); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h80;
    @(negedge clk); rx_data = 8'h03; rst = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rst = 1'b0; cs_n = 1'b1;
    n_cmp++; if (tx_enable !== 1'b0 || pkt_start !== 1'b0 || tx_load_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctrl: txen=%0b start=%0b load=%0b want 000", tx_enable, pkt_start, tx_load_en); end
    n_cmp++; if (channel !== 6'h00 || access_addr !== 32'h8E89BED6 || tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_regs: ch=%02h aa=%08h tx=%02h want 00/8E89BED6/00", channel, access_addr, tx_data); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int addrs[10];
    int n;
    addrs = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 126};
    m_tx_en = 1'b0; m_ch = '0; m_aa = 32'h8E89BED6; m_len = '0; m_err = 1'b0;
    for (int f = 0; f < 60; f++) begin
      pkt_busy = 1'($urandom_range(0, 1));
      frame_q.delete();
      frame_q.push_back({1'($urandom_range(0, 1)), 7'(addrs[$urandom_range(0, 9)])});
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
      send_frame(1'b1);
      model_frame();
      for (int i = 0; i < frame_q.size(); i++) begin
        n_cmp++; if (obs_load[i] !== 1'b1 || obs_tx[i] !== exp_tx[i]) begin n_bad++; $display("FAIL rnd_tx f%0d b%0d: load=%0b data=%02h want 1/%02h", f, i, obs_load[i], obs_tx[i], exp_tx[i]); end
        n_cmp++; if (obs_pw[i] !== exp_pw[i] || (exp_pw[i] && obs_pwd[i] !== frame_q[i])) begin n_bad++; $display("FAIL rnd_pay f%0d b%0d: en=%0b data=%02h want %0b/%02h", f, i, obs_pw[i], obs_pwd[i], exp_pw[i], frame_q[i]); end
        n_cmp++; if (obs_ps[i] !== exp_ps[i]) begin n_bad++; $display("FAIL rnd_start f%0d b%0d: got %0b want %0b", f, i, obs_ps[i], exp_ps[i]); end
      end
      n_cmp++;
      if (channel !== m_ch || access_addr !== m_aa || pay_len !== m_len || tx_enable !== m_tx_en) begin
        n_bad++;
        $display("FAIL rnd_regs f%0d: ch=%02h aa=%08h len=%02h txen=%0b want %02h/%08h/%02h/%0b",
                 f, channel, access_addr, pay_len, tx_enable, m_ch, m_aa, m_len, m_tx_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_channel();
    test_access_addr();
    test_payload();
    test_start();
    test_wrap();
    test_cs_abort();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
